// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: queues {pc, instr} from fetch and hands them to decode in order.
// Latency: one cycle from accepted push to visibility on id_*; no empty bypass.
// Backpressure: if_ready_o drops only when full; a full buffer refuses pushes even while popping.

// Generic circular FIFO with synchronous flush and occupancy count.
// Latency: one cycle push-to-head; outputs derive from registered state only.
// Backpressure: push_rdy low when full, independent of pop_rdy.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push, pop;

    assign push_rdy = (cnt != CW'(DEPTH));
    assign pop_vld  = (cnt != '0);
    assign push     = push_vld && push_rdy && !flush;
    assign pop      = pop_vld && pop_rdy && !flush;
    // Stale storage must never leak onto the head while empty.
    assign pop_dat  = pop_vld ? mem[rp] : '0;
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     if_valid_i,
    input  logic [PC_W-1:0]          if_pc_i,
    input  logic [31:0]              if_instr_i,
    output logic                     if_ready_o,
    output logic                     id_valid_o,
    output logic [PC_W-1:0]          id_pc_o,
    output logic [31:0]              id_instr_o,
    input  logic                     id_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t in_dat, out_dat;

    assign in_dat.pc    = if_pc_i;
    assign in_dat.instr = if_instr_i;
    assign id_pc_o      = out_dat.pc;
    assign id_instr_o   = out_dat.instr;

    fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush_i),
        .push_vld (if_valid_i),
        .push_dat (in_dat),
        .push_rdy (if_ready_o),
        .pop_vld  (id_valid_o),
        .pop_rdy  (id_ready_i),
        .pop_dat  (out_dat),
        .count    (count_o)
    );
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed test-plan steps followed by random traffic,
// all checked against a queue-based reference model.
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int PC_W  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            if_valid_i;
    logic [PC_W-1:0] if_pc_i;
    logic [31:0]     if_instr_i;
    logic            if_ready_o;
    logic            id_valid_o;
    logic [PC_W-1:0] id_pc_o;
    logic [31:0]     id_instr_o;
    logic            id_ready_i;
    logic            flush_i;
    logic [CW-1:0]   count_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t q[$];

    fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_instr_i (if_instr_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_instr_o (id_instr_o),
        .id_ready_i (id_ready_i),
        .flush_i    (flush_i),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] epc;
        logic [31:0] ein;
        epc = '0;
        ein = '0;
        if (q.size() != 0) begin
            epc = q[0].pc;
            ein = q[0].instr;
        end
        check({tag, ".id_valid"}, 64'(id_valid_o), 64'(q.size() != 0));
        check({tag, ".if_ready"}, 64'(if_ready_o), 64'(q.size() < DEPTH));
        check({tag, ".count"},    64'(count_o),    64'(q.size()));
        check({tag, ".id_pc"},    id_pc_o,         epc);
        check({tag, ".id_instr"}, 64'(id_instr_o), 64'(ein));
    endtask

    // Drive one cycle, advance the model by the rules, then compare after the edge.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic r, input logic f, input string tag);
        bit do_push, do_pop;
        if_valid_i = v;
        if_pc_i    = pc;
        if_instr_i = ins;
        id_ready_i = r;
        flush_i    = f;
        if (f) begin
            q.delete();
        end else begin
            do_push = v && (q.size() < DEPTH);
            do_pop  = r && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{pc, ins});
        end
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic mid_reset(input string tag);
        #2;
        rst_i = 1'b1;
        q.delete();
        #1;
        check_all(tag);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] fill_ins [4];
        fill_ins[0] = 32'h00000013;
        fill_ins[1] = 32'h00100093;
        fill_ins[2] = 32'h00200113;
        fill_ins[3] = 32'h00300193;

        rst_i      = 1'b1;
        if_valid_i = 1'b0;
        if_pc_i    = '0;
        if_instr_i = '0;
        id_ready_i = 1'b0;
        flush_i    = 1'b0;
        #1;
        check_all("reset");
        #7;
        rst_i = 1'b0;

        // Fill with decode stalled, then attempt a fifth push.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(4 * i), fill_ins[i], 1'b0, 1'b0, "fill");
        check("fill.count", 64'(count_o), 64'd4);
        check("fill.if_ready", 64'(if_ready_o), 64'd0);
        cycle(1'b1, 64'h10, 32'hdeadbeef, 1'b0, 1'b0, "fifth_push");
        check("full.head_pc", id_pc_o, 64'h0);
        check("full.head_instr", 64'(id_instr_o), 64'h00000013);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            check("drain.pc", id_pc_o, 64'(4 * i));
            cycle(1'b0, '0, '0, 1'b1, 1'b0, "drain");
        end
        check("drain.empty", 64'(id_valid_o), 64'd0);

        // Empty: id_ready_i must be ignored.
        cycle(1'b0, '0, '0, 1'b1, 1'b0, "empty_pop");

        // Preload two, then stream through the pointer wrap.
        cycle(1'b1, 64'h200, 32'h1000, 1'b0, 1'b0, "preload");
        cycle(1'b1, 64'h204, 32'h1001, 1'b0, 1'b0, "preload");
        for (int i = 0; i < 10; i++) begin
            check("stream.pc", id_pc_o, 64'h200 + 64'(4 * i));
            cycle(1'b1, 64'h208 + 64'(4 * i), 32'h1002 + 32'(i), 1'b1, 1'b0, "stream");
            check("stream.count", 64'(count_o), 64'd2);
        end

        // Push and pop together at cnt=1.
        cycle(1'b0, '0, '0, 1'b1, 1'b0, "to_one");
        cycle(1'b1, 64'h300, 32'h2000, 1'b1, 1'b0, "pushpop1");
        check("pushpop1.count", 64'(count_o), 64'd1);
        check("pushpop1.pc", id_pc_o, 64'h300);

        // Push and pop together at cnt=4: push refused.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'h304 + 64'(4 * i), 32'h2001 + 32'(i), 1'b0, 1'b0, "refill");
        cycle(1'b1, 64'h400, 32'h3000, 1'b1, 1'b0, "pushpop_full");
        check("pushpop_full.count", 64'(count_o), 64'd3);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, "after_full_pop");

        // Flush at cnt=3 with a concurrent push and pop.
        cycle(1'b1, 64'hdead, 32'hdead, 1'b1, 1'b1, "flush");
        check("flush.count", 64'(count_o), 64'd0);
        cycle(1'b1, 64'h100, 32'h4000, 1'b0, 1'b0, "post_flush");
        check("post_flush.pc", id_pc_o, 64'h100);

        // Asynchronous reset with cnt=3, between edges.
        cycle(1'b1, 64'h104, 32'h4001, 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 64'h108, 32'h4002, 1'b0, 1'b0, "pre_rst");
        check("pre_rst.count", 64'(count_o), 64'd3);
        if_valid_i = 1'b0;
        mid_reset("async_rst");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, "rand");
        end

        if_valid_i = 1'b0;
        id_ready_i = 1'b0;
        flush_i    = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
